// File: rtl/tm1638_frame_seq.sv
// tm1638_frame_seq
//   Frame sequencer that feeds a serial byte transmitter. Holds a 16-byte
//   display image written by the host and streams a refresh frame, one byte
//   per handshake: mode cmd, address cmd, 16 image bytes, display-control cmd.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data   host write port into the display image
//   start         one-cycle frame request (latched if it arrives mid-frame)
//   brightness, display_on  sampled when a frame is triggered
//   tx_busy       busy flag from the byte transmitter
//   tx_data_rdy   one-cycle byte-valid pulse to the transmitter
//   tx_data       byte to send; held until the next pulse
//   tx_last       byte closes a strobe group
//   frame_busy    frame in progress
//   frame_done    one-cycle pulse after the last byte completes
//   diag_state    main FSM state encoding
//
// Transmitter handshake: a byte is offered (tx_data_rdy pulse) only in a
// cycle where tx_busy = 0. The sequencer then waits for tx_busy = 1 as the
// acceptance, and for tx_busy = 0 again as completion, before moving on.
// tx_data/tx_last are not touched between the pulse and the next pulse.
module tm1638_frame_seq #(
  parameter int          REFRESH_CYCLES = 1_000_000,
  parameter logic [7:0]  CMD_MODE       = 8'h40,
  parameter logic [7:0]  CMD_ADDR       = 8'hC0,
  parameter logic [7:0]  CMD_CTRL_BASE  = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [2:0] brightness,
  input  logic       display_on,
  input  logic       tx_busy,
  output logic       tx_data_rdy,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic       frame_busy,
  output logic       frame_done,
  output logic [2:0] diag_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MODE = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CTRL = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    P_ISSUE = 2'd0,
    P_ACK   = 2'd1,
    P_DONE  = 2'd2
  } phase_t;

  // A zero refresh period still needs a legal (unused) counter width.
  localparam int CW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  // Image is not reset; it powers up cleared through its configuration value.
  logic [7:0] image [16] = '{default: 8'h00};

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [3:0]    idx, idx_n;
  logic          dirty, start_pend;
  logic [CW-1:0] refresh_cnt;
  logic [7:0]    ctrl_q, ctrl_n;
  logic          load_frame;
  logic          refresh_hit;
  logic          trigger;
  logic [7:0]    byte_sel;
  logic          last_sel;
  logic          tx_data_rdy_n, tx_last_n, frame_busy_n, frame_done_n;
  logic [7:0]    tx_data_n;

  assign diag_state  = state;
  assign refresh_hit = (REFRESH_CYCLES != 0) && (refresh_cnt == REFRESH_LAST);
  assign trigger     = start || start_pend || dirty || refresh_hit;

  always_ff @(posedge clk) begin
    if (wr_en) image[wr_addr] <= wr_data;
  end

  // Byte and group marker for the current state. ADDR opens the data group,
  // which is closed by image byte 15.
  always_comb begin
    byte_sel = 8'h00;
    last_sel = 1'b0;
    case (state)
      S_MODE: begin byte_sel = CMD_MODE; last_sel = 1'b1; end
      S_ADDR: begin byte_sel = CMD_ADDR; last_sel = 1'b0; end
      S_DATA: begin byte_sel = image[idx]; last_sel = (idx == 4'd15); end
      S_CTRL: begin byte_sel = ctrl_q; last_sel = 1'b1; end
      default: begin byte_sel = 8'h00; last_sel = 1'b0; end
    endcase
  end

  always_comb begin
    state_n       = state;
    phase_n       = phase;
    idx_n         = idx;
    ctrl_n        = ctrl_q;
    load_frame    = 1'b0;
    tx_data_rdy_n = 1'b0;
    tx_data_n     = tx_data;
    tx_last_n     = tx_last;
    frame_busy_n  = frame_busy;
    frame_done_n  = 1'b0;
    if (state == S_IDLE) begin
      if (trigger) begin
        state_n      = S_MODE;
        phase_n      = P_ISSUE;
        idx_n        = 4'd0;
        ctrl_n       = CMD_CTRL_BASE | {4'b0000, display_on, brightness};
        frame_busy_n = 1'b1;
        load_frame   = 1'b1;
      end
    end else begin
      case (phase)
        P_ISSUE: begin
          if (!tx_busy) begin
            tx_data_rdy_n = 1'b1;
            tx_data_n     = byte_sel;
            tx_last_n     = last_sel;
            phase_n       = P_ACK;
          end
        end
        P_ACK: begin
          if (tx_busy) phase_n = P_DONE;
        end
        P_DONE: begin
          if (!tx_busy) begin
            phase_n = P_ISSUE;
            case (state)
              S_MODE: state_n = S_ADDR;
              S_ADDR: begin state_n = S_DATA; idx_n = 4'd0; end
              S_DATA: begin
                // idx wraps 15 -> 0 exactly on the move to CTRL
                idx_n = idx + 4'd1;
                if (idx == 4'd15) state_n = S_CTRL;
              end
              S_CTRL: begin
                state_n      = S_IDLE;
                frame_busy_n = 1'b0;
                frame_done_n = 1'b1;
              end
              default: state_n = S_IDLE;
            endcase
          end
        end
        default: phase_n = P_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= P_ISSUE;
      idx         <= 4'd0;
      ctrl_q      <= 8'h00;
      dirty       <= 1'b1;
      start_pend  <= 1'b0;
      refresh_cnt <= '0;
      tx_data_rdy <= 1'b0;
      tx_data     <= 8'h00;
      tx_last     <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      idx         <= idx_n;
      ctrl_q      <= ctrl_n;
      tx_data_rdy <= tx_data_rdy_n;
      tx_data     <= tx_data_n;
      tx_last     <= tx_last_n;
      frame_busy  <= frame_busy_n;
      frame_done  <= frame_done_n;
      // A write wins over the clear so a write racing the trigger still
      // produces a follow-up frame.
      if (wr_en) dirty <= 1'b1;
      else if (load_frame) dirty <= 1'b0;
      if (start && (state != S_IDLE)) start_pend <= 1'b1;
      else if (load_frame) start_pend <= 1'b0;
      if (load_frame) refresh_cnt <= '0;
      else if ((state == S_IDLE) && (REFRESH_CYCLES != 0)) refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_tm1638_frame_seq.sv
// Bench for tm1638_frame_seq: a reactive transmitter model, a negedge
// monitor holding a reference image and expected frame layout, and a
// directed-then-random stimulus sequence.
module tb_tm1638_frame_seq;
  localparam int REFRESH = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [2:0] brightness;
  logic       display_on;
  logic       tx_busy;
  logic       tx_data_rdy;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       frame_busy;
  logic       frame_done;
  logic [2:0] diag_state;

  logic       hold_busy;

  // clock / reset
  always #5 clk = ~clk;

  tm1638_frame_seq #(.REFRESH_CYCLES(REFRESH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .brightness(brightness), .display_on(display_on),
    .tx_busy(tx_busy), .tx_data_rdy(tx_data_rdy), .tx_data(tx_data),
    .tx_last(tx_last), .frame_busy(frame_busy), .frame_done(frame_done),
    .diag_state(diag_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // transmitter model: busy rises the cycle after it sees the pulse and
  // stays up 1..4 cycles; hold_busy forces it high
  initial begin
    int left;
    logic pend;
    left = 0; pend = 1'b0; tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        left = 0; pend = 1'b0; tx_busy = 1'b0;
      end else begin
        if (pend) begin left = $urandom_range(1, 4); pend = 1'b0; end
        if (tx_data_rdy) pend = 1'b1;
        tx_busy = (left > 0) || hold_busy;
        if (left > 0) left--;
      end
    end
  end

  // reference model / scoreboard
  logic [7:0] model_img [16];
  logic [7:0] prev_img  [16];
  logic [7:0] got_bytes [19];
  logic [7:0] prev_ctrl, frame_ctrl, last_byte;
  logic       prev_fb, prev_busy, prev_rdy;
  int         k = 0;
  int         cyc = 0;
  int         frames_started = 0, frames_done = 0;
  int         last_start_cyc = 0, last_done_cyc = 0;

  initial begin
    logic [7:0] eb;
    logic       el;
    for (int i = 0; i < 16; i++) begin model_img[i] = 8'h00; prev_img[i] = 8'h00; end
    for (int i = 0; i < 19; i++) got_bytes[i] = 8'h00;
    prev_ctrl = 8'h80; frame_ctrl = 8'h80; last_byte = 8'h00;
    prev_fb = 1'b0; prev_busy = 1'b0; prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        k = 0;
        last_byte = 8'h00;
      end else begin
        if (frame_busy && !prev_fb) begin
          frame_ctrl = prev_ctrl;
          k = 0;
          frames_started++;
          last_start_cyc = cyc;
        end
        if (tx_data_rdy) begin
          check_eq("issue_while_busy", prev_busy, 1'b0);
          check_eq("back_to_back", prev_rdy, 1'b0);
          check_eq("pulse_in_frame", frame_busy, 1'b1);
          if (k < 19) begin
            if (k == 0) eb = 8'h40;
            else if (k == 1) eb = 8'hC0;
            else if (k < 18) eb = prev_img[k-2];
            else eb = frame_ctrl;
            el = (k == 0) || (k == 17) || (k == 18);
            check_eq($sformatf("byte%0d", k), tx_data, eb);
            check_eq($sformatf("last%0d", k), tx_last, el);
            got_bytes[k] = tx_data;
          end else begin
            check_eq("extra_byte", k, 18);
          end
          k++;
          last_byte = tx_data;
        end else if (tx_busy && frame_busy) begin
          check_eq("data_stable", tx_data, last_byte);
        end
        if (frame_done) begin
          check_eq("frame_len", k, 19);
          check_eq("busy_at_done", frame_busy, 1'b0);
          frames_done++;
          last_done_cyc = cyc;
        end
      end
      prev_fb   = frame_busy;
      prev_busy = tx_busy;
      prev_rdy  = tx_data_rdy;
      prev_ctrl = 8'h80 | {4'b0000, display_on, brightness};
      prev_img  = model_img;
      if (wr_en) model_img[wr_addr] = wr_data;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int fd, n;
    fd = frames_done; n = 0;
    while (frames_done == fd && n < budget) begin tick(); n++; end
    check_eq("wait_done", frames_done > fd, 1'b1);
  endtask

  task automatic wait_start(input int budget);
    int fs, n;
    fs = frames_started; n = 0;
    while (frames_started == fs && n < budget) begin tick(); n++; end
    check_eq("wait_start", frames_started > fs, 1'b1);
  endtask

  task automatic wait_quiet(input int budget);
    int q, n;
    q = 0; n = 0;
    while (q < 6 && n < budget) begin
      tick(); n++;
      if (frame_busy) q = 0; else q++;
    end
    check_eq("quiet", q >= 6, 1'b1);
  endtask

  task automatic wait_bytes(input int cnt, input int budget);
    int n;
    n = 0;
    while (k < cnt && n < budget) begin tick(); n++; end
    check_eq("wait_bytes", k >= cnt, 1'b1);
  endtask

  task automatic hold_test();
    int pulses;
    pulses = 0;
    hold_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 2 && tx_data_rdy) pulses++;
    end
    hold_busy = 1'b0;
    check_eq("pulse_under_hold", pulses, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00; start = 1'b0;
    brightness = 3'd0; display_on = 1'b0; hold_busy = 1'b0;
    repeat (3) tick();
    check_eq("rst_rdy", tx_data_rdy, 1'b0);
    check_eq("rst_data", tx_data, 8'h00);
    check_eq("rst_last", tx_last, 1'b0);
    check_eq("rst_fbusy", frame_busy, 1'b0);
    check_eq("rst_fdone", frame_done, 1'b0);
    check_eq("rst_state", diag_state, 3'd0);
    rst = 1'b0;

    // dirty after reset forces a frame of the blank image
    wait_done(1000);
    check_eq("t1_mode", got_bytes[0], 8'h40);
    check_eq("t1_addr", got_bytes[1], 8'hC0);
    check_eq("t1_d3", got_bytes[5], 8'h00);
    check_eq("t1_ctrl", got_bytes[18], 8'h80);
    wait_quiet(1000);

    // directed image content and control byte
    brightness = 3'd7; display_on = 1'b1;
    host_write(4'd0, 8'h3F);
    host_write(4'd15, 8'h06);
    pulse_start();
    wait_quiet(3000);
    check_eq("t2_d0", got_bytes[2], 8'h3F);
    check_eq("t2_d1", got_bytes[3], 8'h00);
    check_eq("t2_d15", got_bytes[17], 8'h06);
    check_eq("t2_ctrl", got_bytes[18], 8'h8F);

    // transmitter stalls mid-frame
    pulse_start();
    wait_bytes(4, 500);
    hold_test();
    wait_quiet(3000);

    // start during a frame is serviced right after frame_done
    pulse_start();
    wait_bytes(3, 500);
    pulse_start();
    wait_done(1000);
    wait_start(10);
    check_eq("restart_gap", (last_start_cyc - last_done_cyc) <= 2, 1'b1);
    wait_quiet(3000);

    // automatic refresh with no host activity
    wait_start(200);
    check_eq("refresh_gap1", last_start_cyc - last_done_cyc, REFRESH);
    wait_done(1000);
    wait_start(200);
    check_eq("refresh_gap2", last_start_cyc - last_done_cyc, REFRESH);
    wait_quiet(3000);

    // randomized writes, control values, starts and stalls
    for (int r = 0; r < 8; r++) begin
      brightness = 3'($urandom_range(0, 7));
      display_on = 1'($urandom_range(0, 1));
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
        host_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 30)) tick();
      end
      if ($urandom_range(0, 1) == 1) pulse_start();
      if ($urandom_range(0, 2) == 0 && frame_busy) hold_test();
      wait_quiet(4000);
    end

    // reset while DATA byte 5 is in flight
    pulse_start();
    wait_bytes(8, 1000);
    rst = 1'b1;
    tick();
    check_eq("t6_fbusy", frame_busy, 1'b0);
    check_eq("t6_rdy", tx_data_rdy, 1'b0);
    check_eq("t6_state", diag_state, 3'd0);
    rst = 1'b0;
    wait_done(1000);
    check_eq("t6_restart_mode", got_bytes[0], 8'h40);
    wait_quiet(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
